// File: rtl/alu_operand_stage_if.sv
// Issue, writeback and ALU-side handshake bundle for the operand-fetch stage.
// master = pipeline control / ALU side, slave = alu_operand_stage.
interface alu_operand_stage_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
);
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [AW-1:0]    in_rs1;
  logic [AW-1:0]    in_rs2;
  logic [WIDTH-1:0] in_imm;
  logic             in_use_imm;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic [2:0]       out_op;

  modport master (
    output wr_en, wr_addr, wr_data,
    output in_valid, in_op, in_rs1, in_rs2, in_imm, in_use_imm,
    input  in_ready,
    input  out_valid, out_a, out_b, out_op,
    output out_ready
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  in_valid, in_op, in_rs1, in_rs2, in_imm, in_use_imm,
    output in_ready,
    output out_valid, out_a, out_b, out_op,
    input  out_ready
  );
endinterface

// File: rtl/alu_operand_stage.sv
// Operand-fetch stage: register file with write bypass, immediate select, and a
// 2-entry (main + skid) output buffer so in_ready never depends on out_ready.
module alu_operand_stage #(
  parameter int WIDTH = 8,
  parameter int NREGS = 8,
  parameter int AW    = 3
) (
  input logic             clk,
  input logic             rst_n,
  alu_operand_stage_if.slave bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

  buf_state_e       r_state;
  buf_state_e       w_state_nxt;

  logic [WIDTH-1:0] r_regs [NREGS];

  logic [WIDTH-1:0] r_main_a, r_main_b;
  logic [2:0]       r_main_op;
  logic [WIDTH-1:0] r_skid_a, r_skid_b;
  logic [2:0]       r_skid_op;

  logic [WIDTH-1:0] w_rs1_data, w_rs2_data;
  logic [WIDTH-1:0] w_new_a, w_new_b;
  logic             w_issue, w_fire;
  logic             w_load_main, w_load_skid, w_main_from_skid;

  // Handshake flags decode straight from the state register.
  assign bus.in_ready  = (r_state != ST_FULL);
  assign bus.out_valid = (r_state != ST_EMPTY);
  assign bus.out_a     = r_main_a;
  assign bus.out_b     = r_main_b;
  assign bus.out_op    = r_main_op;

  assign w_issue = bus.in_valid & bus.in_ready;
  assign w_fire  = bus.out_valid & bus.out_ready;

  // Register reads see a same-cycle writeback; r0 always reads zero.
  always_comb begin
    w_rs1_data = '0;
    w_rs2_data = '0;
    if (bus.in_rs1 != '0)
      w_rs1_data = (bus.wr_en && bus.wr_addr == bus.in_rs1) ? bus.wr_data
                                                            : r_regs[bus.in_rs1];
    if (bus.in_rs2 != '0)
      w_rs2_data = (bus.wr_en && bus.wr_addr == bus.in_rs2) ? bus.wr_data
                                                            : r_regs[bus.in_rs2];
  end

  assign w_new_a = w_rs1_data;
  assign w_new_b = bus.in_use_imm ? bus.in_imm : w_rs2_data;

  // NOTE: the register file is small and must read zero after reset, so it is
  // reset explicitly like any other flop rather than left uninitialised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (bus.wr_en && bus.wr_addr != '0) begin
      r_regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // NOTE: all combinational outputs get defaults first so no latch is inferred.
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main      = 1'b0;
    w_load_skid      = 1'b0;
    w_main_from_skid = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_issue) begin
          w_state_nxt = ST_ONE;
          w_load_main = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_issue && w_fire) begin
          w_load_main = 1'b1;
        end else if (w_issue) begin
          w_state_nxt = ST_FULL;
          w_load_skid = 1'b1;
        end else if (w_fire) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_fire) begin
          w_state_nxt      = ST_ONE;
          w_load_main      = 1'b1;
          w_main_from_skid = 1'b1;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_a  <= '0;
      r_main_b  <= '0;
      r_main_op <= '0;
      r_skid_a  <= '0;
      r_skid_b  <= '0;
      r_skid_op <= '0;
    end else begin
      if (w_load_main) begin
        if (w_main_from_skid) begin
          r_main_a  <= r_skid_a;
          r_main_b  <= r_skid_b;
          r_main_op <= r_skid_op;
        end else begin
          r_main_a  <= w_new_a;
          r_main_b  <= w_new_b;
          r_main_op <= bus.in_op;
        end
      end
      if (w_load_skid) begin
        r_skid_a  <= w_new_a;
        r_skid_b  <= w_new_b;
        r_skid_op <= bus.in_op;
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Randomised and directed bench for alu_operand_stage: a driver pushes expected
// operands from a plain register-array model, a monitor pops them on output.
module tb_alu_operand_stage;
  localparam int WIDTH = 8;
  localparam int NREGS = 8;
  localparam int AW    = 3;
  localparam logic [2:0] OP_AND = 3'd0;

  typedef struct packed {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } exp_t;

  typedef struct packed {
    logic             v;
    logic [2:0]       op;
    logic [AW-1:0]    rs1;
    logic [AW-1:0]    rs2;
    logic [WIDTH-1:0] imm;
    logic             ui;
    logic             we;
    logic [AW-1:0]    wa;
    logic [WIDTH-1:0] wd;
    logic             rdy;
  } stim_t;

  logic clk;
  logic rst_n;

  alu_operand_stage_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  alu_operand_stage #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  int n_popped = 0;
  exp_t scb_q[$];
  logic [WIDTH-1:0] model_regs [NREGS];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference read: zero register, same-cycle writeback wins, else stored value.
  function automatic logic [WIDTH-1:0] model_read(input logic [AW-1:0] rs, input stim_t s);
    if (rs == 0) return '0;
    if (s.we && s.wa == rs) return s.wd;
    return model_regs[rs];
  endfunction

  function automatic stim_t idle(input logic rdy);
    stim_t s;
    s = '0;
    s.rdy = rdy;
    return s;
  endfunction

  // Drive after one edge; decide acceptance before the next edge samples it.
  task automatic cycle(input stim_t s, output bit acc);
    exp_t e;
    @(posedge clk);
    #1;
    bus.in_valid   = s.v;
    bus.in_op      = s.op;
    bus.in_rs1     = s.rs1;
    bus.in_rs2     = s.rs2;
    bus.in_imm     = s.imm;
    bus.in_use_imm = s.ui;
    bus.wr_en      = s.we;
    bus.wr_addr    = s.wa;
    bus.wr_data    = s.wd;
    bus.out_ready  = s.rdy;
    @(negedge clk);
    acc = s.v && (bus.in_ready === 1'b1);
    if (acc) begin
      e.op = s.op;
      e.a  = model_read(s.rs1, s);
      e.b  = s.ui ? s.imm : model_read(s.rs2, s);
      scb_q.push_back(e);
    end
    if (s.we && s.wa != 0) model_regs[s.wa] = s.wd;
  endtask

  task automatic drain(input string name);
    bit acc;
    for (int i = 0; i < 40 && scb_q.size() != 0; i++) cycle(idle(1'b1), acc);
    check(name, 32'(scb_q.size()), 32'd0);
  endtask

  task automatic reset_model();
    scb_q.delete();
    for (int i = 0; i < NREGS; i++) model_regs[i] = '0;
  endtask

  // Monitor: every cycle with valid output, the head of the queue must be shown.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid === 1'b1) begin
      if (scb_q.size() == 0) begin
        check("unexpected_output", {13'd0, bus.out_op, bus.out_a, bus.out_b}, 32'hDEAD);
      end else begin
        check("out_op_a_b", {13'd0, bus.out_op, bus.out_a, bus.out_b},
              {13'd0, scb_q[0].op, scb_q[0].a, scb_q[0].b});
        if (bus.out_ready === 1'b1) begin
          void'(scb_q.pop_front());
          n_popped++;
        end
      end
    end
  end

  initial begin
    stim_t s;
    bit    acc;
    bit    acc_log [3];
    int    n_acc;
    int    pop0;

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_op = '0; bus.in_rs1 = '0; bus.in_rs2 = '0;
    bus.in_imm = '0; bus.in_use_imm = 1'b0; bus.wr_en = 1'b0; bus.wr_addr = '0;
    bus.wr_data = '0; bus.out_ready = 1'b0;
    reset_model();
    #12;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_outputs", {13'd0, bus.out_op, bus.out_a, bus.out_b}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Basic AND issue with register operands.
    s = idle(1'b1); s.we = 1; s.wa = 3'd1; s.wd = 8'd34; cycle(s, acc);
    s = idle(1'b1); s.we = 1; s.wa = 3'd2; s.wd = 8'd50; cycle(s, acc);
    s = idle(1'b1); s.v = 1; s.op = OP_AND; s.rs1 = 3'd1; s.rs2 = 3'd2; cycle(s, acc);
    check("and_accept", {31'd0, acc}, 32'd1);
    cycle(idle(1'b1), acc);
    check("and_result", {24'd0, bus.out_a & bus.out_b}, 32'd34);
    drain("drain_and");

    // Same-cycle writeback bypass with immediate B.
    s = idle(1'b1); s.v = 1; s.op = 3'd3; s.rs1 = 3'd3; s.imm = 8'd20; s.ui = 1;
    s.we = 1; s.wa = 3'd3; s.wd = 8'd12; cycle(s, acc);
    drain("drain_bypass");

    // r0 stays zero whether written the same cycle or earlier.
    s = idle(1'b1); s.v = 1; s.op = 3'd1; s.rs1 = 3'd0; s.rs2 = 3'd0;
    s.we = 1; s.wa = 3'd0; s.wd = 8'hFF; cycle(s, acc);
    s = idle(1'b1); s.v = 1; s.op = 3'd2; s.rs1 = 3'd0; s.rs2 = 3'd1; cycle(s, acc);
    drain("drain_r0");

    // Backpressure: third back-to-back issue is refused until space opens.
    for (int i = 0; i < 3; i++) begin
      s = idle(1'b0); s.v = 1; s.op = 3'(i + 4); s.rs1 = 3'd1; s.rs2 = 3'd2;
      cycle(s, acc);
      acc_log[i] = acc;
    end
    check("bp_accept_pattern", {29'd0, acc_log[0], acc_log[1], acc_log[2]}, 32'b110);
    check("bp_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
    acc = 0;
    for (int i = 0; i < 10 && !acc; i++) begin
      s = idle(1'b1); s.v = 1; s.op = 3'd6; s.rs1 = 3'd1; s.rs2 = 3'd2; cycle(s, acc);
    end
    check("bp_third_accepted", {31'd0, acc}, 32'd1);
    drain("drain_bp");

    // Streaming: one issue per cycle with the ALU always ready.
    n_acc = 0;
    pop0 = n_popped;
    for (int i = 0; i < 16; i++) begin
      s = idle(1'b1); s.v = 1; s.op = 3'($urandom_range(0, 7));
      s.rs1 = 3'($urandom_range(0, 7)); s.rs2 = 3'($urandom_range(0, 7));
      s.imm = 8'($urandom); s.ui = 1'($urandom);
      cycle(s, acc);
      if (acc) n_acc++;
    end
    check("stream_accepts", 32'(n_acc), 32'd16);
    drain("drain_stream");
    check("stream_outputs", 32'(n_popped - pop0), 32'd16);

    // Randomised traffic with random backpressure and writebacks.
    for (int i = 0; i < 300; i++) begin
      s.v   = 1'($urandom_range(0, 3) != 0);
      s.op  = 3'($urandom);
      s.rs1 = 3'($urandom);
      s.rs2 = 3'($urandom);
      s.imm = 8'($urandom);
      s.ui  = 1'($urandom);
      s.we  = 1'($urandom);
      s.wa  = 3'($urandom);
      s.wd  = 8'($urandom);
      s.rdy = 1'($urandom_range(0, 2) != 0);
      cycle(s, acc);
    end
    drain("drain_random");

    // Reset in the middle of a stalled stream drops everything.
    for (int i = 0; i < 3; i++) begin
      s = idle(1'b0); s.v = 1; s.op = 3'd5; s.rs1 = 3'd1; s.rs2 = 3'd2;
      s.we = 1; s.wa = 3'(i + 4); s.wd = 8'hA5; cycle(s, acc);
    end
    bus.in_valid = 1'b0;
    bus.wr_en    = 1'b0;
    #3;
    rst_n = 1'b0;
    reset_model();
    #1;
    check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("midrst_outputs", {13'd0, bus.out_op, bus.out_a, bus.out_b}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    s = idle(1'b1); s.v = 1; s.op = 3'd7; s.rs1 = 3'd1; s.rs2 = 3'd2; cycle(s, acc);
    s = idle(1'b1); s.v = 1; s.op = 3'd7; s.rs1 = 3'd4; s.rs2 = 3'd5; cycle(s, acc);
    drain("drain_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
